// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM state type and default parameters for clk_div_monitor.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;
  localparam int CNT_W_DEF = 8;
  localparam int EXP_PERIOD_DEF = 4;
endpackage

// File: rtl/clk_edge_detect.sv
// clk_edge_detect: samples clk_in as data and flags its rising edge.
// Defining CLK_DIV_MONITOR_SYNC_EN adds a 2-flop synchronizer in front of the edge detector.
module clk_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  output logic s,
  output logic rise
);
  logic s_q;
`ifdef CLK_DIV_MONITOR_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync <= '0;
    else sync <= {sync[0], clk_in};
  assign s = sync[1];
`else
  assign s = clk_in;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) s_q <= 1'b0;
    else s_q <= s;
  assign rise = s & ~s_q;
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of a divided clock in clk cycles and reports lock/error.
// Build with CLK_DIV_MONITOR_SYNC_EN to synchronize clk_in from another domain (+2 cycles latency).
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0] EXP_P = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0] EXP_H = (CNT_W+1)'(EXP_PERIOD >> 1);
  localparam logic [CNT_W:0] TOL_V = (CNT_W+1)'(TOL);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  state_t state, state_n;
  logic s, rise, meas, tmo, match, set_err;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [MW-1:0] mcnt, mcnt_inc;
  logic [CNT_W:0] dp, dh;

  clk_edge_detect u_edge (.clk, .rst, .clk_in, .s, .rise);

  // one extra bit keeps the difference from wrapping
  function automatic logic [CNT_W:0] absd(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  assign meas = en && state == MEASURE && rise;
  assign tmo = en && state == MEASURE && !rise && cnt == '1;
  assign dp = absd({1'b0, cnt}, EXP_P);
  assign dh = absd({1'b0, hcnt}, EXP_H);
  assign match = dp <= TOL_V && dh <= TOL_V;
  assign set_err = (meas && !match) || tmo;
  assign mcnt_inc = (mcnt == LOCK_V) ? mcnt : mcnt + 1'b1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    state_n = !en ? IDLE :
              state == IDLE ? WAIT_EDGE :
              (state == WAIT_EDGE && rise) ? MEASURE :
              tmo ? WAIT_EDGE : state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      hcnt <= '0;
      mcnt <= '0;
      period <= '0;
      high_time <= '0;
      meas_valid <= 1'b0;
      locked <= 1'b0;
      err <= 1'b0;
    end else begin
      meas_valid <= meas;
      err <= set_err | (err & ~err_clr);
      if (!en || state == IDLE) begin
        cnt <= '0;
        hcnt <= '0;
        mcnt <= '0;
        locked <= 1'b0;
      end else if (state == WAIT_EDGE) begin
        if (rise) begin
          cnt <= CNT_W'(1);
          hcnt <= CNT_W'(1);
        end
      end else if (meas) begin
        period <= cnt;
        high_time <= hcnt;
        cnt <= CNT_W'(1);
        hcnt <= CNT_W'(1);
        mcnt <= match ? mcnt_inc : '0;
        locked <= match && mcnt_inc == LOCK_V;
      end else if (tmo) begin
        mcnt <= '0;
        locked <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        hcnt <= hcnt + CNT_W'(s);
      end
    end
  end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: randomized bench comparing clk_div_monitor against a sample-history reference model.
module tb_clk_div_monitor;
  localparam int CNT_W = 8, EXP = 4, TOL = 0, LOCK = 4;
  logic clk = 0, rst = 0, en = 0, clk_in = 0, err_clr = 0;
  logic [CNT_W-1:0] period, high_time;
  logic meas_valid, locked, err;
  int n_chk = 0, n_fail = 0;
  int m_period, m_high, m_mv, m_locked, m_err, phase, mc, mv_seen, clr_odds;
  bit prev, en_g;
  bit dly[$];
  int hist[$];

  clk_div_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst(rst), .en(en), .clk_in(clk_in), .err_clr(err_clr),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_period = 0; m_high = 0; m_mv = 0; m_locked = 0; m_err = 0;
    phase = 0; mc = 0; prev = 0;
    hist.delete();
    dly.delete();
    dly.push_back(0);
    dly.push_back(0);
  endtask

  // phase: 0 idle, 1 waiting for first rise, 2 measuring; hist holds samples since last rise
  task automatic model_edge(input bit e, input bit ci, input bit clr);
    bit c, r, set;
    int p, h;
`ifdef CLK_DIV_MONITOR_SYNC_EN
    dly.push_back(ci);
    c = dly.pop_front();
`else
    c = ci;
`endif
    r = c && !prev;
    prev = c;
    m_mv = 0;
    set = 0;
    if (!e) begin
      phase = 0; mc = 0; m_locked = 0;
    end else if (phase == 0) phase = 1;
    else if (phase == 1) begin
      if (r) begin phase = 2; hist.delete(); hist.push_back(1); end
    end else if (r) begin
      p = hist.size();
      h = 0;
      foreach (hist[i]) h += hist[i];
      m_mv = 1; m_period = p; m_high = h;
      if ((p > EXP ? p - EXP : EXP - p) <= TOL && (h > EXP/2 ? h - EXP/2 : EXP/2 - h) <= TOL) begin
        if (mc < LOCK) mc++;
        m_locked = (mc == LOCK);
      end else begin
        mc = 0; m_locked = 0; set = 1;
      end
      hist.delete();
      hist.push_back(1);
    end else if (hist.size() == 2**CNT_W - 1) begin
      phase = 1; mc = 0; m_locked = 0; set = 1;
    end else hist.push_back(int'(c));
    m_err = set ? 1 : (clr ? 0 : m_err);
  endtask

  task automatic step(input bit c, input bit e, input bit clr);
    clk_in = c; en = e; err_clr = clr;
    @(posedge clk);
    model_edge(e, c, clr);
    @(negedge clk);
    check("period", period, m_period);
    check("high_time", high_time, m_high);
    check("meas_valid", meas_valid, m_mv);
    check("locked", locked, m_locked);
    check("err", err, m_err);
    if (meas_valid) mv_seen++;
  endtask

  task automatic run_div(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hi + lo; j++)
        step(j < hi, en_g, clr_odds != 0 && $urandom_range(clr_odds - 1) == 0);
    end
  endtask

  initial begin
    model_reset();
    en_g = 1;
    clr_odds = 0;
    repeat (2) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_mv", meas_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    rst = 1;
    repeat (2) step(0, 1, 0);
    run_div(2, 2, 10);
    check("div4_lock", locked, 1);
    check("div4_period", period, 4);
    check("div4_high", high_time, 2);
    check("div4_err", err, 0);
    run_div(3, 3, 2);
    check("div6_period", period, 6);
    check("div6_high", high_time, 3);
    check("div6_unlock", locked, 0);
    check("div6_err", err, 1);
    step(1, 1, 1);
    check("clr_race", err, 1);
    step(1, 1, 1);
    check("clr_alone", err, 0);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    run_div(3, 1, 6);
    check("duty_high", high_time, 3);
    check("duty_err", err, 1);
    check("duty_unlock", locked, 0);
    run_div(2, 2, 8);
    step(0, 1, 1);
    check("relock_a", locked, 1);
    check("relock_err", err, 0);
    mv_seen = 0;
    repeat (300) step(0, 1, 0);
    check("stuck_lo_err", err, 1);
    check("stuck_lo_unlock", locked, 0);
    check("stuck_lo_mv", mv_seen, 0);
    run_div(2, 2, 6);
    check("relock_b", locked, 1);
    repeat (300) step(1, 1, 0);
    check("stuck_hi_err", err, 1);
    check("stuck_hi_unlock", locked, 0);
    step(1, 1, 1);
    check("stuck_hi_clr", err, 0);
    run_div(2, 2, 6);
    check("relock_c", locked, 1);
    step(1, 1, 0);
    step(1, 0, 0);
    check("en_unlock", locked, 0);
    check("en_hold_period", period, 4);
    check("en_hold_high", high_time, 2);
    step(0, 0, 0);
    step(0, 1, 0);
    clr_odds = 8;
    repeat (25) begin
      en_g = $urandom_range(9) != 0;
      run_div($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 6));
    end
    en_g = 1;
    clr_odds = 0;
    run_div(2, 2, 6);
    step(1, 1, 0);
    #1 rst = 0;
    #1;
    check("areset_period", period, 0);
    check("areset_high", high_time, 0);
    check("areset_mv", meas_valid, 0);
    check("areset_locked", locked, 0);
    check("areset_err", err, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    mv_seen = 0;
    step(1, 1, 0);
    step(0, 1, 0);
    check("areset_no_early_mv", mv_seen, 0);
    run_div(2, 2, 6);
    check("areset_relock", locked, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
